// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit Harvard CPU.
// Owns PC and IR; emits per-state strobes for regfile, ALU and data memory.
module cpu_sequencer #(
  parameter int PC_W = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [15:0]     imem_rdata,
  input  logic            zero_in,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc_out,
  output logic [15:0]     ir,
  output logic [2:0]      rf_raddr_a,
  output logic [2:0]      rf_raddr_b,
  output logic [2:0]      rf_waddr,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [1:0]      alu_op,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [PC_W-1:0] dmem_addr,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [15:0]     retired_q, retired_d;
  logic            retire;

  logic [3:0] opc;
  logic is_alu, is_ldi, is_ld, is_st, is_jmp, is_beqz, is_halt;

  assign opc     = ir_q[15:12];
  assign is_alu  = (opc >= 4'd1) && (opc <= 4'd4);
  assign is_ldi  = (opc == 4'd5);
  assign is_ld   = (opc == 4'd6);
  assign is_st   = (opc == 4'd7);
  assign is_jmp  = (opc == 4'd8);
  assign is_beqz = (opc == 4'd9);
  assign is_halt = (opc == 4'hF);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    retire   = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    alu_op   = 2'b00;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else if (is_ld || is_st) begin
          state_d = S_MEM;
        end else if (is_alu || is_ldi || is_jmp || is_beqz) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        if (is_alu) begin
          rf_we  = 1'b1;
          alu_op = opc[1:0] - 2'd1;
        end
        if (is_ldi) begin
          rf_we  = 1'b1;
          wb_sel = 2'b01;
        end
        if (is_jmp || (is_beqz && zero_in))
          pc_d = ir_q[PC_W-1:0];
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) begin
          if (is_st) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        wb_sel  = 2'b10;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
    retired_d = retired_q + 16'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign pc_out     = pc_q;
  assign ir         = ir_q;
  assign rf_raddr_a = ir_q[11:9];
  assign rf_raddr_b = ir_q[8:6];
  assign rf_waddr   = ir_q[11:9];
  assign dmem_addr  = ir_q[PC_W-1:0];
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted     = (state_q == S_HALT);
  assign retired    = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: instruction-level model expands each instruction
// into its expected cycle schedule; directed programs pin the model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] imem_rdata;
  logic        zero_in = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [5:0]  pc_out;
  logic [15:0] ir;
  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we;
  logic [1:0]  wb_sel, alu_op;
  logic        dmem_req, dmem_we;
  logic [5:0]  dmem_addr;
  logic        busy, halted;
  logic [15:0] retired;

  logic [15:0] imem [64];
  assign imem_rdata = imem[pc_out];

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_rdata(imem_rdata), .zero_in(zero_in), .dmem_ack(dmem_ack),
    .pc_out(pc_out), .ir(ir),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_waddr(rf_waddr), .rf_we(rf_we), .wb_sel(wb_sel),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .busy(busy), .halted(halted),
    .retired(retired)
  );

  // One expected cycle: input drives plus the outputs that must be seen.
  typedef struct {
    logic        st, ack, z;
    logic [5:0]  pc;
    logic [15:0] ir;
    logic        rf_we;
    logic [1:0]  wb, alu;
    logic        req, we;
    logic        busy, halted;
    logic [15:0] ret;
  } rec_t;

  rec_t q[$];

  int total = 0;
  int bad = 0;

  // model state: 0 idle, 1 running, 2 halted
  int          mode;
  logic [5:0]  m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_ret;
  bit          go_req;
  int          force_z;     // 0 random, 1 -> zero_in=1, 2 -> zero_in=0
  int          force_n;     // 0 random MEM length, else fixed
  bit          stray_all;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t base(input logic [5:0] pc, input logic [15:0] irv);
    rec_t r;
    r.st = 1'($urandom_range(0, 1));
    r.ack = stray_all ? 1'b1 : 1'($urandom_range(0, 1));
    r.z = 1'($urandom_range(0, 1));
    r.pc = pc; r.ir = irv;
    r.rf_we = 0; r.wb = 0; r.alu = 0; r.req = 0; r.we = 0;
    r.busy = 1; r.halted = 0; r.ret = m_ret;
    return r;
  endfunction

  task automatic gen();
    rec_t r;
    logic [15:0] i;
    logic [3:0]  op;
    logic [5:0]  nxt;
    int n;
    if (mode == 0) begin
      r = base(m_pc, m_ir);
      r.busy = 0; r.st = go_req;
      q.push_back(r);
      if (go_req) begin mode = 1; go_req = 0; end
    end else if (mode == 2) begin
      r = base(m_pc, m_ir);
      r.busy = 0; r.halted = 1;
      q.push_back(r);
    end else begin
      i = imem[m_pc];
      op = i[15:12];
      q.push_back(base(m_pc, m_ir));
      nxt = m_pc + 6'd1;
      q.push_back(base(nxt, i));
      if (op >= 1 && op <= 5) begin
        r = base(nxt, i);
        r.rf_we = 1;
        if (op == 5) r.wb = 2'b01;
        else r.alu = 2'(op - 1);
        q.push_back(r);
      end else if (op == 8 || op == 9) begin
        r = base(nxt, i);
        if (force_z == 1) r.z = 1;
        if (force_z == 2) r.z = 0;
        if (op == 8 || r.z) nxt = i[5:0];
        q.push_back(r);
      end else if (op == 6 || op == 7) begin
        n = (force_n != 0) ? force_n : $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          r = base(nxt, i);
          r.req = 1; r.we = (op == 7);
          r.ack = (k == n - 1);
          q.push_back(r);
        end
        if (op == 6) begin
          r = base(nxt, i);
          r.rf_we = 1; r.wb = 2'b10;
          q.push_back(r);
        end
      end
      m_pc = nxt;
      m_ir = i;
      m_ret = m_ret + 16'd1;
      if (op == 4'hF) mode = 2;
    end
  endtask

  task automatic cycle();
    rec_t r;
    @(negedge clk);
    if (q.size() == 0) gen();
    r = q.pop_front();
    reset = 0;
    start = r.st;
    dmem_ack = r.ack;
    zero_in = r.z;
    chk("pc_out", 16'(pc_out), 16'(r.pc));
    chk("ir", ir, r.ir);
    chk("rf_raddr_a", 16'(rf_raddr_a), 16'(r.ir[11:9]));
    chk("rf_raddr_b", 16'(rf_raddr_b), 16'(r.ir[8:6]));
    chk("rf_waddr", 16'(rf_waddr), 16'(r.ir[11:9]));
    chk("rf_we", 16'(rf_we), 16'(r.rf_we));
    chk("wb_sel", 16'(wb_sel), 16'(r.wb));
    chk("alu_op", 16'(alu_op), 16'(r.alu));
    chk("dmem_req", 16'(dmem_req), 16'(r.req));
    chk("dmem_we", 16'(dmem_we), 16'(r.we));
    chk("dmem_addr", 16'(dmem_addr), 16'(r.ir[5:0]));
    chk("busy", 16'(busy), 16'(r.busy));
    chk("halted", 16'(halted), 16'(r.halted));
    chk("retired", retired, r.ret);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = 1; start = 1; dmem_ack = 1;
    end
    q.delete();
    mode = 0; m_pc = 0; m_ir = 0; m_ret = 0;
    go_req = 0; force_z = 0; force_n = 0; stray_all = 0;
  endtask

  task automatic load(input logic [15:0] a0, input logic [15:0] a63);
    foreach (imem[k]) imem[k] = 16'h0000;
    imem[0] = a0;
    imem[63] = a63;
  endtask

  task automatic go();
    go_req = 1;
    cycle();
  endtask

  initial begin
    logic [3:0] op;
    load(16'h0000, 16'h0000);
    do_reset(2);
    repeat (5) cycle();
    chk("rst_pc", 16'(pc_out), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_we", 16'(rf_we), 16'd0);
    chk("rst_req", 16'(dmem_req), 16'd0);
    chk("rst_ret", retired, 16'd0);

    // LDI r1,5 ; ADD r1,r1
    do_reset(2);
    load(16'h5205, 16'h0000);
    imem[1] = 16'h1240;
    go();
    repeat (3) cycle();
    chk("ldi_we", 16'(rf_we), 16'd1);
    chk("ldi_wb", 16'(wb_sel), 16'd1);
    chk("ldi_wa", 16'(rf_waddr), 16'd1);
    repeat (3) cycle();
    chk("add_we", 16'(rf_we), 16'd1);
    chk("add_wb", 16'(wb_sel), 16'd0);
    chk("add_op", 16'(alu_op), 16'd0);
    cycle();
    chk("add_pc", 16'(pc_out), 16'd2);
    chk("add_ret", retired, 16'd2);

    // JMP 63 then NOP at 63 wraps to 0
    do_reset(1);
    load(16'h803F, 16'h0000);
    go();
    repeat (4) cycle();
    chk("jmp_pc", 16'(pc_out), 16'd63);
    cycle();
    chk("wrap_pc", 16'(pc_out), 16'd0);
    cycle();
    chk("jmp_ret", retired, 16'd2);

    // BEQZ taken / not taken
    for (int t = 1; t <= 2; t++) begin
      do_reset(1);
      load(16'h9005, 16'h0000);
      force_z = t;
      go();
      repeat (4) cycle();
      chk("beqz_pc", 16'(pc_out), (t == 1) ? 16'd5 : 16'd1);
    end

    // LD with ack on 3rd MEM cycle, stray acks everywhere else
    do_reset(1);
    load(16'h6203, 16'h0000);
    force_n = 3;
    stray_all = 1;
    go();
    repeat (2) cycle();
    chk("ld_dec_req", 16'(dmem_req), 16'd0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("ld_req", 16'(dmem_req), 16'd1);
      chk("ld_addr", 16'(dmem_addr), 16'd3);
      chk("ld_we", 16'(dmem_we), 16'd0);
    end
    cycle();
    chk("ld_wb_req", 16'(dmem_req), 16'd0);
    chk("ld_wb_we", 16'(rf_we), 16'd1);
    chk("ld_wb_sel", 16'(wb_sel), 16'd2);

    // HALT absorbs, start pulses ignored
    do_reset(1);
    load(16'hF000, 16'h0000);
    go();
    repeat (8) cycle();
    chk("halt_h", 16'(halted), 16'd1);
    chk("halt_busy", 16'(busy), 16'd0);
    chk("halt_ret", retired, 16'd1);

    // reset during a MEM wait
    do_reset(1);
    load(16'h7003, 16'h0000);
    force_n = 8;
    go();
    repeat (4) cycle();
    chk("st_req", 16'(dmem_req), 16'd1);
    do_reset(1);
    cycle();
    chk("abort_req", 16'(dmem_req), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);

    // random programs, each begun by a reset at an arbitrary state
    for (int p = 0; p < 24; p++) begin
      do_reset($urandom_range(1, 2));
      foreach (imem[k]) begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 5) != 0) op = 4'h5;
        imem[k] = {op, 12'($urandom)};
      end
      repeat ($urandom_range(0, 3)) cycle();
      go();
      repeat ($urandom_range(40, 160)) cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control unit for the 16-bit Harvard CPU. It owns the program counter and instruction register, fetches from instruction memory, and decodes each instruction into per-cycle strobes for the register file, ALU and data memory. It handles data-memory wait states through a req/ack handshake. It sits between the instruction ROM and the datapath, replacing free-running PC stepping with a start/halt-controlled FSM.

## Interface
- PC_W, 6, program counter and instruction/data address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin execution; sampled only in IDLE
- imem_rdata  in  16  instruction at address pc_out (combinational ROM)
- zero_in  in  1  datapath flag: register ir[11:9] reads zero
- dmem_ack  in  1  data memory completes current request
- pc_out  out  PC_W  program counter = instruction memory address
- ir  out  16  instruction register
- rf_raddr_a  out  3  ir[11:9]
- rf_raddr_b  out  3  ir[8:6]
- rf_waddr  out  3  ir[11:9]
- rf_we  out  1  register file write strobe
- wb_sel  out  2  write-back source: 00 ALU, 01 immediate, 10 memory
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR (= opcode−1 for opcodes 1–4)
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_addr  out  PC_W  ir[PC_W-1:0]
- busy  out  1  1 in every state except IDLE and HALT
- halted  out  1  1 in HALT
- retired  out  16  count of completed instructions, wraps modulo 2^16

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs, [5:0] imm/addr.
- Opcodes:
  - 0 NOP
  - 1–4 ALU: rd ← rd op rs
  - 5 LDI: rd ← imm
  - 6 LD: rd ← dmem[addr]
  - 7 ST: dmem[addr] ← rd
  - 8 JMP: pc ← addr
  - 9 BEQZ: branch to addr if zero_in
  - F HALT
  - All other opcodes execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE → FETCH when start = 1; otherwise hold.
- FETCH: ir ← imem_rdata, pc ← pc+1 (wraps 63→0) → DECODE.
- DECODE:
  - NOP: → FETCH (retire).
  - HALT: → HALT (retire).
  - LD/ST: → MEM.
  - All others: → EXEC.
- EXEC:
  - ALU: rf_we = 1, wb_sel = 00, alu_op driven.
  - LDI: rf_we = 1, wb_sel = 01.
  - JMP: pc ← addr.
  - BEQZ: pc ← addr if zero_in = 1, else pc unchanged.
  - Always → FETCH (retire).
- MEM: dmem_req = 1, dmem_we = (opcode == 7). Hold until dmem_ack. On ack, LD → WB, ST → FETCH (retire).
- WB: rf_we = 1, wb_sel = 10 → FETCH (retire).
- HALT: absorbing. start is ignored; only reset exits.
- Retire means retired increments on the cycle the FSM leaves the last state of an instruction.
- Strobes (rf_we, wb_sel, alu_op, dmem_req, dmem_we) are combinational from state and ir. They are 0 in all states not listed above.

## Timing
- Reset values:
  - state IDLE, pc_out = RESET_PC, ir = 0, retired = 0
  - all strobes 0, busy = 0, halted = 0
  - These take effect at the first edge where reset = 1.
- Reset mid-operation (including in MEM with dmem_req high) aborts the instruction. dmem_req drops after that edge; the PC and retired count are not preserved.
- Cycles per instruction:
  - NOP / HALT: 2
  - ALU / LDI / JMP / BEQZ: 3
  - ST: 2 + n
  - LD: 3 + n
  - n ≥ 1 is the number of MEM cycles, inclusive of the ack cycle.
- dmem_ack is ignored outside MEM. dmem_addr and dmem_we are stable for the whole request.
- start is ignored outside IDLE. start asserted during reset is ignored.
- The first FETCH occurs the cycle after start is sampled.
- Branch/jump targets are visible on pc_out in the cycle after EXEC.

## Test plan
- Reset held 2 cycles, start = 0 for 5 cycles → pc_out = 0, busy = 0, rf_we = dmem_req = 0, retired = 0.
- imem[0] = 0x5205 (LDI r1,5), imem[1] = 0x1240 (ADD r1,r1), start pulse → the following must hold:
  - 3rd cycle after start: rf_we = 1, wb_sel = 01, rf_waddr = 1.
  - 6th cycle after start: rf_we = 1, wb_sel = 00, alu_op = 00.
  - Then pc_out = 2, retired = 2.
- imem[0] = 0x803F (JMP 63), imem[63] = 0x0000 → pc_out = 63 after JMP, then 0 after the NOP fetch (wrap); retired = 2.
- BEQZ 0x9005 at address 0:
  - zero_in = 1 → pc_out = 5.
  - Rerun with zero_in = 0 → pc_out = 1.
- LD 0x6203 with dmem_ack on the 3rd MEM cycle, plus a stray ack during DECODE → stray ack ignored; dmem_req high exactly 3 cycles with dmem_addr = 3, dmem_we = 0; then one WB cycle with rf_we = 1, wb_sel = 10.
- imem[0] = 0xF000 → halted = 1, busy = 0, retired = 1; start pulses ignored. Separately, reset asserted during a MEM wait → IDLE and dmem_req = 0 the next cycle.
